// File: rtl/conv_ctrl_16_4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_ctrl_pkg
//  Brief    : Shared types and sizes for the 1-D convolution control unit
//             (16 input samples, 4 filter taps, 13 outputs per vector).
//  Revision : 1.0  initial release
// ============================================================================
package conv_ctrl_pkg;

    localparam int N     = 16;          // samples per input vector
    localparam int M     = 4;           // filter taps
    localparam int N_OUT = N - M + 1;   // outputs per input vector
    localparam int AW_X  = $clog2(N);   // input-memory address width
    localparam int AW_F  = $clog2(M);   // filter-ROM address width

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MAC   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_ctrl_16_4_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_ctrl_16_4_if
//  Brief    : Handshake and memory-control bundle between the convolution
//             controller (master) and its datapath/environment (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface conv_ctrl_16_4_if;
    import conv_ctrl_pkg::*;

    logic            x_valid;
    logic            x_ready;
    logic            wr_en_x;
    logic [AW_X-1:0] addr_x;
    logic [AW_F-1:0] addr_f;
    logic            clear_acc;
    logic            en_acc;
    logic            y_valid;
    logic            y_ready;

    // Controller side
    modport master (
        input  x_valid, y_ready,
        output x_ready, wr_en_x, addr_x, addr_f, clear_acc, en_acc, y_valid
    );

    // Datapath / environment side
    modport slave (
        output x_valid, y_ready,
        input  x_ready, wr_en_x, addr_x, addr_f, clear_acc, en_acc, y_valid
    );

endinterface
`default_nettype wire

// File: rtl/conv_ctrl_16_4.sv
`default_nettype none
// ============================================================================
//  Module   : conv_ctrl_16_4
//  Brief    : Sequencer for a 16-sample / 4-tap 1-D convolution datapath.
//             Loads a vector, then for each of 13 outputs issues 4 MAC reads,
//             one flush cycle, and presents the result on y_valid/y_ready.
//  Revision : 1.0  initial release
// ============================================================================
module conv_ctrl_16_4
    import conv_ctrl_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    conv_ctrl_16_4_if.master bus
);

    state_t          state;
    state_t          state_nxt;
    logic [AW_X-1:0] wcnt;
    logic [AW_X-1:0] out_idx;
    logic [AW_F-1:0] tap;

    logic last_sample;
    logic last_tap;
    logic last_out;

    assign last_sample = (wcnt    == AW_X'(N - 1));
    assign last_tap    = (tap     == AW_F'(M - 1));
    assign last_out    = (out_idx == AW_X'(N - M));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // Next-state and state-decoded outputs; x_ready/y_valid depend on state only
    always_comb begin
        state_nxt   = state;
        bus.x_ready = 1'b0;
        bus.wr_en_x = 1'b0;
        bus.y_valid = 1'b0;
        bus.addr_x  = out_idx + AW_X'(tap);
        bus.addr_f  = tap;
        case (state)
            LOAD: begin
                bus.x_ready = 1'b1;
                bus.wr_en_x = bus.x_valid;
                bus.addr_x  = wcnt;
                if (bus.x_valid && last_sample) state_nxt = MAC;
            end
            MAC: begin
                if (last_tap) state_nxt = FLUSH;
            end
            FLUSH: begin
                state_nxt = OUT;
            end
            OUT: begin
                bus.y_valid = 1'b1;
                if (bus.y_ready) state_nxt = last_out ? LOAD : MAC;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Sample, output-index and tap counters; tap is parked at 0 outside MAC so
    // addresses stay static while a result waits in OUT
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt    <= '0;
            out_idx <= '0;
            tap     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.x_valid) begin
                        if (last_sample) begin
                            wcnt    <= '0;
                            out_idx <= '0;
                            tap     <= '0;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    tap <= last_tap ? '0 : tap + 1'b1;
                end
                OUT: begin
                    if (bus.y_ready && !last_out) begin
                        out_idx <= out_idx + 1'b1;
                        tap     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulator controls lag the address issue by one cycle to meet memory data
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.en_acc    <= 1'b0;
            bus.clear_acc <= 1'b0;
        end else begin
            bus.en_acc    <= (state == MAC);
            bus.clear_acc <= (state == MAC) && (tap == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_ctrl_16_4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_ctrl_16_4
//  Brief    : Self-checking bench for conv_ctrl_16_4: a vector table for the
//             first load/MAC/OUT sequence, a schedule-based reference model for
//             directed, stalled, reset-interrupted and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_ctrl_16_4;

    localparam int NS   = 16;
    localparam int MT   = 4;
    localparam int NO   = 13;
    localparam int NVEC = 300;

    logic clk;
    logic reset;
    conv_ctrl_16_4_if bus();

    conv_ctrl_16_4 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic xv, yr;
        logic e_rdy, e_wr, e_yv, e_en, e_clr, chk_a;
        int   e_ax, e_af;
    } vec_t;

    function automatic vec_t mk(input logic xv, yr, rdy, wr, yv, en, clr, ca,
                                input int ax, af);
        vec_t v;
        v.xv = xv; v.yr = yr; v.e_rdy = rdy; v.e_wr = wr; v.e_yv = yv;
        v.e_en = en; v.e_clr = clr; v.chk_a = ca; v.e_ax = ax; v.e_af = af;
        return v;
    endfunction

    vec_t tbl[25];

    // ---------------- reference model ----------------
    // The expected life of a vector is expanded into a schedule of issue
    // slots: per output k, four MAC slots (k+j, j), one flush, one result.
    typedef struct { int kind; int k; int j; } slot_t;   // kind 0 MAC,1 FLUSH,2 OUT
    slot_t sched[$];
    int    loaded;
    bit    prev_mac, prev_clr;
    bit    hold_valid;
    int    hold_ax, hold_af;
    int    n_out;

    task automatic model_reset();
        sched.delete();
        loaded = 0; prev_mac = 0; prev_clr = 0; hold_valid = 0;
    endtask

    task automatic build_sched();
        for (int k = 0; k < NO; k++) begin
            for (int j = 0; j < MT; j++) sched.push_back('{0, k, j});
            sched.push_back('{1, k, 0});
            sched.push_back('{2, k, 0});
        end
    endtask

    task automatic model_cycle(input bit xv, input bit yr);
        bit nm, nc;
        slot_t s;
        bus.x_valid = xv;
        bus.y_ready = yr;
        #1;
        nm = 0; nc = 0;
        if (sched.size() == 0) begin
            chk("x_ready_load", int'(bus.x_ready), 1);
            chk("wr_en_load",   int'(bus.wr_en_x), int'(xv));
            chk("y_valid_load", int'(bus.y_valid), 0);
            chk("addr_x_load",  int'(bus.addr_x),  loaded);
        end else begin
            s = sched[0];
            chk("x_ready_busy", int'(bus.x_ready), 0);
            chk("wr_en_busy",   int'(bus.wr_en_x), 0);
            chk("y_valid",      int'(bus.y_valid), (s.kind == 2) ? 1 : 0);
            if (s.kind == 0) begin
                chk("addr_x_mac", int'(bus.addr_x), s.k + s.j);
                chk("addr_f_mac", int'(bus.addr_f), s.j);
                nm = 1;
                nc = (s.j == 0);
            end else if (s.kind == 2) begin
                if (hold_valid) begin
                    chk("addr_x_hold", int'(bus.addr_x), hold_ax);
                    chk("addr_f_hold", int'(bus.addr_f), hold_af);
                end else begin
                    hold_valid = 1;
                    hold_ax = int'(bus.addr_x);
                    hold_af = int'(bus.addr_f);
                end
            end
        end
        chk("en_acc",    int'(bus.en_acc),    int'(prev_mac));
        chk("clear_acc", int'(bus.clear_acc), int'(prev_clr));
        @(posedge clk);
        #1;
        if (sched.size() == 0) begin
            if (xv) begin
                loaded++;
                if (loaded == NS) begin
                    loaded = 0;
                    build_sched();
                end
            end
        end else if (sched[0].kind == 2) begin
            if (yr) begin
                void'(sched.pop_front());
                hold_valid = 0;
                n_out++;
            end
        end else begin
            void'(sched.pop_front());
        end
        prev_mac = nm;
        prev_clr = nc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.x_valid = 1'b0;
        bus.y_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int base, guard;
        bit found;

        // Table: first vector load, first output, start of second output
        for (int i = 0; i < NS; i++)
            tbl[i] = mk(1, 0, 1, 1, 0, 0, 0, 1, i, 0);
        for (int j = 0; j < MT; j++)
            tbl[NS + j] = mk(1, 0, 0, 0, 0, (j >= 1), (j == 1), 1, j, j);
        tbl[20] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);   // flush, last product lands
        tbl[21] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);   // result shown, stalled
        tbl[22] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);   // result accepted
        tbl[23] = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);   // output 1, tap 0
        tbl[24] = mk(0, 1, 0, 0, 0, 1, 1, 1, 2, 1);   // output 1, tap 1

        reset = 1'b1;
        n_out = 0;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            bus.x_valid = tbl[i].xv;
            bus.y_ready = tbl[i].yr;
            #1;
            chk($sformatf("t%0d_x_ready", i), int'(bus.x_ready), int'(tbl[i].e_rdy));
            chk($sformatf("t%0d_wr_en",   i), int'(bus.wr_en_x), int'(tbl[i].e_wr));
            chk($sformatf("t%0d_y_valid", i), int'(bus.y_valid), int'(tbl[i].e_yv));
            chk($sformatf("t%0d_en_acc",  i), int'(bus.en_acc),  int'(tbl[i].e_en));
            chk($sformatf("t%0d_clr_acc", i), int'(bus.clear_acc), int'(tbl[i].e_clr));
            if (tbl[i].chk_a) begin
                chk($sformatf("t%0d_addr_x", i), int'(bus.addr_x), tbl[i].e_ax);
                chk($sformatf("t%0d_addr_f", i), int'(bus.addr_f), tbl[i].e_af);
            end
            @(posedge clk); #1;
        end

        // Directed full vector with y_ready held high
        do_reset();
        base = n_out;
        for (int c = 0; c < NS; c++) model_cycle(1, 1);
        for (int c = 0; c < NO * (MT + 2); c++) model_cycle(1, 1);
        chk("full_vec_outputs", n_out - base, NO);
        chk("full_vec_back_to_load", int'(bus.x_ready), 1);

        // Stall a result for 20 cycles
        for (int c = 0; c < NS; c++) model_cycle(1, 0);
        for (int c = 0; c < MT + 1; c++) model_cycle(0, 0);
        for (int c = 0; c < 20; c++) model_cycle(1, 0);
        chk("stall_y_valid", int'(bus.y_valid), 1);
        chk("stall_en_acc",  int'(bus.en_acc),  0);
        for (int c = 0; c < NO * (MT + 2) + 4; c++) model_cycle(0, 1);

        // Reset in the middle of MAC for output 7
        found = 0;
        for (guard = 0; guard < 200; guard++) begin
            if (sched.size() > 0 && sched[0].kind == 0 && sched[0].k == 7 && sched[0].j == 1) begin
                found = 1;
                break;
            end
            model_cycle(1, 1);
        end
        chk("reach_mac_out7", int'(found), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        bus.x_valid = 1'b0;
        #1;
        chk("rst_x_ready", int'(bus.x_ready), 1);
        chk("rst_y_valid", int'(bus.y_valid), 0);
        chk("rst_addr_x",  int'(bus.addr_x),  0);
        chk("rst_en_acc",  int'(bus.en_acc),  0);
        base = n_out;
        for (int c = 0; c < NS; c++) model_cycle(1, 1);
        for (int c = 0; c < NO * (MT + 2); c++) model_cycle(0, 1);
        chk("post_rst_outputs", n_out - base, NO);

        // Randomized valid/ready traffic against the schedule model
        base = n_out;
        for (int c = 0; c < 60000 && (n_out - base) < NVEC * NO; c++)
            model_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        chk("random_outputs", n_out - base, NVEC * NO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
